// File: rtl/obuffer_col.sv
// Output-side column collector: packs DW-bit result elements (first element in the MSB lane)
// into DEPTH*DW-bit words, queues them in a 2-entry FIFO and forwards the skewed strobe.
module obuffer_col #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ShiftEN,
  input  logic [DW-1:0]       ID,
  input  logic                Flush,
  output logic                ShiftEN_o,
  output logic [DEPTH*DW-1:0] OWord,
  output logic                OValid,
  input  logic                OReady,
  output logic [1:0]          Level,
  output logic                Ovf
);

  localparam int unsigned WW = DEPTH * DW;
  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] cnt, cnt_n;
  logic [CW:0]   cnt_after;
  logic [WW-1:0] pack, pack_n, cap_word;
  logic [WW-1:0] q0, q1, q0_n, q1_n;
  logic [1:0]    lvl_n;
  logic          ovf_n;
  logic          full, push, pop;

  // Capture into the current lane, then decide whether this edge pushes a word.
  always_comb begin
    cap_word = pack;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ShiftEN && (cnt == CW'(k))) begin
        cap_word[(DEPTH-1-k)*DW +: DW] = ID;
      end
    end
    cnt_after = {1'b0, cnt} + (CW+1)'(ShiftEN);
    full      = ShiftEN && (cnt == CW'(DEPTH-1));
    push      = full || (Flush && (cnt_after != '0));
    pack_n    = push ? '0 : cap_word;
    cnt_n     = push ? '0 : CW'(cnt_after);
  end

  assign pop = OValid && OReady;

  // Two-entry queue; q0 is the head and is held at zero while the queue is empty.
  always_comb begin
    q0_n  = q0;
    q1_n  = q1;
    lvl_n = Level;
    ovf_n = Ovf;
    case (Level)
      2'd0: begin
        if (push) begin
          q0_n  = cap_word;
          lvl_n = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          q0_n = cap_word;
        end else if (pop) begin
          q0_n  = '0;
          lvl_n = 2'd0;
        end else if (push) begin
          q1_n  = cap_word;
          lvl_n = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          q0_n  = q1;
          q1_n  = push ? cap_word : '0;
          lvl_n = push ? 2'd2 : 2'd1;
        end else if (push) begin
          ovf_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      pack      <= '0;
      q0        <= '0;
      q1        <= '0;
      Level     <= 2'd0;
      OValid    <= 1'b0;
      Ovf       <= 1'b0;
      ShiftEN_o <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      pack      <= pack_n;
      q0        <= q0_n;
      q1        <= q1_n;
      Level     <= lvl_n;
      OValid    <= (lvl_n != 2'd0);
      Ovf       <= ovf_n;
      ShiftEN_o <= ShiftEN;
    end
  end

  assign OWord = q0;

endmodule

// File: tb/tb_obuffer_col.sv
// Directed bench for obuffer_col: packing, flush, backpressure/overflow, full push+pop, reset.
module tb_obuffer_col;

  logic        CLK = 1'b0;
  logic        RST, ShiftEN, Flush, OReady;
  logic [7:0]  ID;
  logic        ShiftEN_o, OValid, Ovf;
  logic [31:0] OWord;
  logic [1:0]  Level;

  int compared = 0;
  int mismatched = 0;

  obuffer_col #(.DW(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .ShiftEN(ShiftEN), .ID(ID), .Flush(Flush),
    .ShiftEN_o(ShiftEN_o), .OWord(OWord), .OValid(OValid), .OReady(OReady),
    .Level(Level), .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [31:0] tmp;
    tmp = w;
    for (int i = 0; i < 4; i++) begin
      ShiftEN = 1'b1;
      ID = tmp[31-8*i -: 8];
      step();
    end
    ShiftEN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ShiftEN = 1'b0; Flush = 1'b0; OReady = 1'b0; ID = 8'h00;
    step(); step();
    chk("rst_ovalid", 32'(OValid), 32'd0);
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_ovf", 32'(Ovf), 32'd0);
    chk("rst_shiften_o", 32'(ShiftEN_o), 32'd0);
    chk("rst_oword", OWord, 32'h0);
    RST = 1'b0;

    // Pack four elements with the writer always ready
    OReady = 1'b1;
    ShiftEN = 1'b1; ID = 8'h11; step();
    chk("pack_shiften_o", 32'(ShiftEN_o), 32'd1);
    chk("pack_not_yet_valid", 32'(OValid), 32'd0);
    ID = 8'h22; step();
    ID = 8'h33; step();
    ID = 8'h44; step();
    ShiftEN = 1'b0;
    chk("pack_valid", 32'(OValid), 32'd1);
    chk("pack_word", OWord, 32'h11223344);
    step();
    chk("pack_drained_valid", 32'(OValid), 32'd0);
    chk("pack_shiften_o_low", 32'(ShiftEN_o), 32'd0);
    chk("pack_drained_word", OWord, 32'h0);

    // Flush a partial word
    OReady = 1'b0;
    ShiftEN = 1'b1; ID = 8'hAA; step();
    ID = 8'hBB; step();
    ShiftEN = 1'b0; Flush = 1'b1; step();
    Flush = 1'b0;
    chk("flush_word", OWord, 32'hAABB0000);
    chk("flush_level", 32'(Level), 32'd1);
    OReady = 1'b1; step();
    chk("flush_drain_level", 32'(Level), 32'd0);
    OReady = 1'b0;
    ShiftEN = 1'b1; ID = 8'hAA; step();
    ID = 8'hBB; step();
    ID = 8'hCC; Flush = 1'b1; step();
    ShiftEN = 1'b0;
    chk("flush_cap_word", OWord, 32'hAABBCC00);
    step();
    chk("flush_empty_no_push", 32'(Level), 32'd1);
    Flush = 1'b0;
    OReady = 1'b1; step();
    chk("flush2_drain_level", 32'(Level), 32'd0);
    chk("flush2_drain_word", OWord, 32'h0);

    // Backpressure with overflow
    OReady = 1'b0;
    push_word(32'h01020304);
    push_word(32'h05060708);
    chk("bp_level2", 32'(Level), 32'd2);
    chk("bp_no_ovf_yet", 32'(Ovf), 32'd0);
    push_word(32'h090A0B0C);
    chk("bp_level_full", 32'(Level), 32'd2);
    chk("bp_ovf", 32'(Ovf), 32'd1);
    chk("bp_head", OWord, 32'h01020304);
    step();
    chk("bp_head_stable", OWord, 32'h01020304);
    OReady = 1'b1; step();
    chk("bp_second", OWord, 32'h05060708);
    chk("bp_level1", 32'(Level), 32'd1);
    step();
    chk("bp_empty", 32'(Level), 32'd0);
    chk("bp_ovf_sticky", 32'(Ovf), 32'd1);

    // Push and pop together at full
    RST = 1'b1; OReady = 1'b0; step();
    RST = 1'b0;
    chk("rst2_ovf", 32'(Ovf), 32'd0);
    push_word(32'h10203040);
    push_word(32'h50607080);
    ShiftEN = 1'b1; ID = 8'h91; step();
    ID = 8'h92; step();
    ID = 8'h93; step();
    ID = 8'h94; OReady = 1'b1; step();
    ShiftEN = 1'b0; OReady = 1'b0;
    chk("pp_level", 32'(Level), 32'd2);
    chk("pp_ovf", 32'(Ovf), 32'd0);
    chk("pp_head", OWord, 32'h50607080);
    OReady = 1'b1; step();
    chk("pp_next", OWord, 32'h91929394);
    step();
    chk("pp_empty", 32'(Level), 32'd0);
    OReady = 1'b0;

    // Reset mid-word discards partial lanes
    ShiftEN = 1'b1; ID = 8'hEE; step();
    ID = 8'hEF; step();
    ShiftEN = 1'b0; RST = 1'b1; step();
    RST = 1'b0;
    chk("rmw_level", 32'(Level), 32'd0);
    push_word(32'h01020304);
    chk("rmw_valid", 32'(OValid), 32'd1);
    chk("rmw_word", OWord, 32'h01020304);
    chk("rmw_level1", 32'(Level), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
